pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Parametrised stall/flush controller for the in-order pipeline; supersedes the fixed 5-stage unit.
//  Arbitrates D-cache miss freeze, I-cache miss bubbles, load-use interlock and branch/jump redirect flush.
//  Drives per-pipeline-register load/reset vectors and PC load.
//  Tracks in-flight wrong-path fetches across cycles and optionally counts hazard events.
// PARAMETERS
//  NUM_STAGES    5   pipeline stages; pipe regs indexed 0..NUM_STAGES-2 (reg k sits between stage k and k+1)
//  REDIRECT_STG  2   stage resolving branches/jumps (EX); redirect flushes regs 0..REDIRECT_STG-1
//  MEM_STG       3   stage accessing the D-cache; must satisfy REDIRECT_STG < MEM_STG <= NUM_STAGES-2
//  REG_W         5   register-index width
//  CNT_W         32  perf counter width
// PORTS
//  clk          in   1        clock
//  rst          in   1        synchronous active-high reset
//  inst_resp    in   1        I-cache returns valid instruction this cycle
//  dmem_req     in   1        MEM-stage instruction is a load or store
//  data_resp    in   1        D-cache completes MEM-stage access this cycle
//  ex_is_load   in   1        instruction in REDIRECT_STG is a load
//  ex_rd        in   REG_W    its destination register
//  id_rs1/id_rs2      in  REG_W  source registers of the decode-stage instruction
//  id_use_rs1/id_use_rs2 in 1    decode-stage instruction reads rs1/rs2
//  redirect     in   1        taken branch or jump resolved in REDIRECT_STG
//  inst_read    out  1        fetch request enable
//  load_pc      out  1        PC register load enable
//  load_pipe    out  NUM_STAGES-1  per-pipe-reg load enable
//  rst_pipe     out  NUM_STAGES-1  per-pipe-reg synchronous bubble insert (wins over load)
//  perf_dstall/perf_istall/perf_luse/perf_flush  out CNT_W  event counters
// BEHAVIOUR
//  Defaults: load_pc=1, load_pipe all 1, rst_pipe all 0, inst_read=1.
//  While rst: load_pc=0, load_pipe=0, rst_pipe all 1, inst_read=0; FSM->RUN; counters->0.
//  Priority, high to low (outputs combinational; one decision per cycle):
//   1 dmiss = dmem_req & ~data_resp: load_pc=0; load_pipe[0..MEM_STG-1]=0; rst_pipe[MEM_STG]=1
//     (no duplicate writeback). Redirect/load-use ignored; they persist because EX is frozen.
//   2 redirect: load_pc=1 (target); rst_pipe[0..REDIRECT_STG-1]=1; perf_flush++.
//     If ~inst_resp, FSM RUN->KILL.
//   3 load-use = ex_is_load & ex_rd!=0 & ((id_use_rs1&id_rs1==ex_rd)|(id_use_rs2&id_rs2==ex_rd)):
//     load_pc=0, load_pipe[0]=0, rst_pipe[1]=1. Single-cycle bubble; forwarding covers the rest.
//   4 imiss = ~inst_resp: load_pc=0, rst_pipe[0]=1; downstream regs advance.
//  FSM: RUN, KILL.
//   KILL: I-cache latches its address at request time, so the in-flight word is wrong-path.
//   KILL & ~inst_resp: hold PC, rst_pipe[0]=1.
//   KILL & inst_resp: discard the word (rst_pipe[0]=1), load_pc=0 (PC already holds target),
//   then ->RUN; target fetched next cycle.
//   KILL & redirect (dmiss absent): stay in KILL; PC reloaded with the new target.
//   dmiss in KILL: freeze per rule 1, FSM unchanged; inst_resp arriving then still ends KILL.
//  Simultaneous: redirect + load-use -> redirect only; load-use + imiss -> load-use (IF/ID held,
//   not flushed); imiss + dmiss -> dmiss freeze.
//  Reset mid-miss: FSM->RUN; next inst_resp is accepted (caches are reset by the same rst).
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: four saturating CNT_W counters, one increment per cycle.
//   perf_dstall counts dmiss cycles; perf_istall counts imiss or KILL cycles not masked by dmiss;
//   perf_luse counts load-use bubbles; perf_flush counts redirects.
//   Cleared by rst; hold at all-ones.
//  Undefined: counter logic absent; perf_* outputs tied to 0.
// TESTING
//  ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1, responses=1 -> 1 cycle load_pc=0, load_pipe[0]=0,
//   rst_pipe[1]=1; next cycle defaults.
//  dmem_req=1, data_resp=0 for 3 cycles -> load_pc=0, load_pipe=4'b1000, rst_pipe=4'b1000 each
//   cycle; perf_dstall=3.
//  redirect=1, inst_resp=0 -> rst_pipe=4'b0011, load_pc=1, FSM=KILL; inst_resp=1 two cycles later
//   -> rst_pipe[0]=1, FSM=RUN.
//  redirect=1 with load-use condition true -> only redirect flush; perf_luse unchanged, perf_flush=1.
//  dmiss + redirect together, data_resp in cycle 3 -> freeze cycles 1-2; flush applied in cycle 3.
//  rst asserted while FSM=KILL -> FSM=RUN, counters 0, outputs at reset values.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the in-order pipeline: D-miss freeze, I-miss bubbles,
// load-use interlock, redirect flush with wrong-path kill tracking. Optional counters: HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int NUM_STAGES   = 5,
  parameter int REDIRECT_STG = 2,
  parameter int MEM_STG      = 3,
  parameter int REG_W        = 5,
  parameter int CNT_W        = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inst_resp,
  input  logic                  dmem_req,
  input  logic                  data_resp,
  input  logic                  ex_is_load,
  input  logic [REG_W-1:0]      ex_rd,
  input  logic [REG_W-1:0]      id_rs1,
  input  logic [REG_W-1:0]      id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  redirect,
  output logic                  inst_read,
  output logic                  load_pc,
  output logic [NUM_STAGES-2:0] load_pipe,
  output logic [NUM_STAGES-2:0] rst_pipe,
  output logic [CNT_W-1:0]      perf_dstall,
  output logic [CNT_W-1:0]      perf_istall,
  output logic [CNT_W-1:0]      perf_luse,
  output logic [CNT_W-1:0]      perf_flush
);

  localparam int NR = NUM_STAGES - 1;
  localparam logic [NR-1:0] ONE      = {{(NR-1){1'b0}}, 1'b1};
  localparam logic [NR-1:0] MEM_FRZ  = (ONE << MEM_STG) - ONE;
  localparam logic [NR-1:0] MEM_BUB  = ONE << MEM_STG;
  localparam logic [NR-1:0] FLUSH_MK = (ONE << REDIRECT_STG) - ONE;

  typedef enum logic {RUN, KILL} state_t;
  state_t state, state_nxt;

  logic dmiss, load_use;

  assign dmiss    = dmem_req & ~data_resp;
  assign load_use = ex_is_load & (ex_rd != '0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    inst_read = 1'b1;
    load_pc   = 1'b1;
    load_pipe = '1;
    rst_pipe  = '0;
    state_nxt = state;
    if (rst) begin
      inst_read = 1'b0;
      load_pc   = 1'b0;
      load_pipe = '0;
      rst_pipe  = '1;
      state_nxt = RUN;
    end else if (dmiss) begin
      // Frozen front end never latches the arriving word, so a kill can still retire here.
      load_pc   = 1'b0;
      load_pipe = ~MEM_FRZ;
      rst_pipe  = MEM_BUB;
      if (state == KILL && inst_resp) state_nxt = RUN;
    end else if (redirect) begin
      rst_pipe = FLUSH_MK;
      if (!inst_resp) state_nxt = KILL;
    end else if (load_use) begin
      load_pc      = 1'b0;
      load_pipe[0] = 1'b0;
      rst_pipe[1]  = 1'b1;
      if (state == KILL && inst_resp) state_nxt = RUN;
    end else if (state == KILL || !inst_resp) begin
      // In KILL the returning word is wrong-path and the PC already holds the target.
      load_pc     = 1'b0;
      rst_pipe[0] = 1'b1;
      if (inst_resp) state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic ev_dstall, ev_istall, ev_luse, ev_flush;

  assign ev_dstall = dmiss;
  assign ev_istall = ~dmiss & (~inst_resp | (state == KILL));
  assign ev_luse   = ~dmiss & ~redirect & load_use;
  assign ev_flush  = ~dmiss & redirect;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_dstall <= '0;
      perf_istall <= '0;
      perf_luse   <= '0;
      perf_flush  <= '0;
    end else begin
      if (ev_dstall && perf_dstall != '1) perf_dstall <= perf_dstall + CNT_W'(1);
      if (ev_istall && perf_istall != '1) perf_istall <= perf_istall + CNT_W'(1);
      if (ev_luse   && perf_luse   != '1) perf_luse   <= perf_luse   + CNT_W'(1);
      if (ev_flush  && perf_flush  != '1) perf_flush  <= perf_flush  + CNT_W'(1);
    end
  end
`else
  assign perf_dstall = '0;
  assign perf_istall = '0;
  assign perf_luse   = '0;
  assign perf_flush  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: per-cycle stimulus queued with expected
// {load_pc, inst_read, load_pipe, rst_pipe}; counters checked against HAZARD_PERF_CNT_EN build.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  localparam logic [9:0] DEF  = 10'b11_1111_0000;
  localparam logic [9:0] RSTV = 10'b00_0000_1111;
  localparam logic [9:0] LUV  = 10'b01_1110_0010;
  localparam logic [9:0] DMV  = 10'b01_1000_1000;
  localparam logic [9:0] RDV  = 10'b11_1111_0011;
  localparam logic [9:0] BUB  = 10'b01_1111_0001;

  logic        clk = 1'b0;
  logic        rst, inst_resp, dmem_req, data_resp, ex_is_load, redirect;
  logic [4:0]  ex_rd, id_rs1, id_rs2;
  logic        id_use_rs1, id_use_rs2;
  logic        inst_read, load_pc;
  logic [3:0]  load_pipe, rst_pipe;
  logic [31:0] perf_dstall, perf_istall, perf_luse, perf_flush;

  int vectors = 0;
  int misc    = 0;

  typedef struct packed {
    logic       rst, inst_resp, dmem_req, data_resp, ex_is_load;
    logic [4:0] ex_rd, id_rs1, id_rs2;
    logic       use1, use2, redirect;
  } stim_t;

  stim_t      stim_q[$];
  logic [9:0] sb[$];

  pipeline_hazard_ctrl #(
    .NUM_STAGES(5), .REDIRECT_STG(2), .MEM_STG(3), .REG_W(5), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .inst_resp(inst_resp), .dmem_req(dmem_req), .data_resp(data_resp),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .redirect(redirect),
    .inst_read(inst_read), .load_pc(load_pc), .load_pipe(load_pipe), .rst_pipe(rst_pipe),
    .perf_dstall(perf_dstall), .perf_istall(perf_istall), .perf_luse(perf_luse),
    .perf_flush(perf_flush)
  );

  always #5 clk = ~clk;

  // lu: 0 none, 1 rs2 hit, 2 rs1 hit, 3 rd=x0, 4 match but unused, 5 match but not a load
  function automatic stim_t st(bit r, bit ir, bit dm, bit dr, bit rd, int lu);
    stim_t s;
    s = '0;
    s.rst = r; s.inst_resp = ir; s.dmem_req = dm; s.data_resp = dr; s.redirect = rd;
    case (lu)
      1: begin s.ex_is_load = 1; s.ex_rd = 5; s.id_rs1 = 3; s.id_rs2 = 5; s.use1 = 1; s.use2 = 1; end
      2: begin s.ex_is_load = 1; s.ex_rd = 7; s.id_rs1 = 7; s.id_rs2 = 2; s.use1 = 1; s.use2 = 1; end
      3: begin s.ex_is_load = 1; s.ex_rd = 0; s.use1 = 1; s.use2 = 1; end
      4: begin s.ex_is_load = 1; s.ex_rd = 9; s.id_rs1 = 9; s.id_rs2 = 9; end
      5: begin s.ex_rd = 9; s.id_rs1 = 9; s.use1 = 1; end
      default: ;
    endcase
    return s;
  endfunction

  function automatic void push(stim_t s, logic [9:0] e);
    stim_q.push_back(s);
    sb.push_back(e);
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst; inst_resp = s.inst_resp; dmem_req = s.dmem_req; data_resp = s.data_resp;
    ex_is_load = s.ex_is_load; ex_rd = s.ex_rd; id_rs1 = s.id_rs1; id_rs2 = s.id_rs2;
    id_use_rs1 = s.use1; id_use_rs2 = s.use2; redirect = s.redirect;
  endtask

  task automatic test_reset();
    stim_t s; logic [9:0] e, got; int i = 0;
    push(st(1,1,0,1,0,0), RSTV);
    push(st(0,1,0,1,0,0), DEF);
    push(st(0,1,0,1,0,5), DEF);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      @(posedge clk); #1; drive(s);
      @(negedge clk);
      got = {load_pc, inst_read, load_pipe, rst_pipe}; e = sb.pop_front(); vectors++;
      if (got !== e) begin misc++; $display("FAIL reset step %0d: got %b expected %b", i, got, e); end
      i++;
    end
    vectors++;
    if ({perf_dstall, perf_istall, perf_luse, perf_flush} !== '0) begin
      misc++; $display("FAIL reset_counters: got %0d/%0d/%0d/%0d expected 0", perf_dstall, perf_istall, perf_luse, perf_flush);
    end
  endtask

  task automatic test_load_use();
    stim_t s; logic [9:0] e, got; int i = 0;
    push(st(1,1,0,1,0,0), RSTV);
    push(st(0,1,0,1,0,1), LUV);
    push(st(0,1,0,1,0,0), DEF);
    push(st(0,1,0,1,0,2), LUV);
    push(st(0,1,0,1,0,3), DEF);
    push(st(0,1,0,1,0,4), DEF);
    push(st(0,0,0,1,0,1), LUV);
    push(st(0,1,0,1,0,0), DEF);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      @(posedge clk); #1; drive(s);
      @(negedge clk);
      got = {load_pc, inst_read, load_pipe, rst_pipe}; e = sb.pop_front(); vectors++;
      if (got !== e) begin misc++; $display("FAIL load_use step %0d: got %b expected %b", i, got, e); end
      i++;
    end
    vectors++;
    if (perf_luse !== 32'(3*P)) begin misc++; $display("FAIL perf_luse: got %0d expected %0d", perf_luse, 3*P); end
  endtask

  task automatic test_imiss();
    stim_t s; logic [9:0] e, got; int i = 0;
    push(st(1,1,0,1,0,0), RSTV);
    push(st(0,0,0,1,0,0), BUB);
    push(st(0,0,0,1,0,0), BUB);
    push(st(0,1,0,1,0,0), DEF);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      @(posedge clk); #1; drive(s);
      @(negedge clk);
      got = {load_pc, inst_read, load_pipe, rst_pipe}; e = sb.pop_front(); vectors++;
      if (got !== e) begin misc++; $display("FAIL imiss step %0d: got %b expected %b", i, got, e); end
      i++;
    end
    vectors++;
    if (perf_istall !== 32'(2*P)) begin misc++; $display("FAIL perf_istall: got %0d expected %0d", perf_istall, 2*P); end
  endtask

  task automatic test_dmiss();
    stim_t s; logic [9:0] e, got; int i = 0;
    push(st(1,1,0,1,0,0), RSTV);
    push(st(0,1,1,0,0,0), DMV);
    push(st(0,1,1,0,0,0), DMV);
    push(st(0,1,1,0,0,0), DMV);
    push(st(0,0,1,0,0,1), DMV);
    push(st(0,1,1,1,0,0), DEF);
    push(st(0,1,0,1,0,0), DEF);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      @(posedge clk); #1; drive(s);
      @(negedge clk);
      got = {load_pc, inst_read, load_pipe, rst_pipe}; e = sb.pop_front(); vectors++;
      if (got !== e) begin misc++; $display("FAIL dmiss step %0d: got %b expected %b", i, got, e); end
      i++;
    end
    vectors += 3;
    if (perf_dstall !== 32'(4*P)) begin misc++; $display("FAIL perf_dstall: got %0d expected %0d", perf_dstall, 4*P); end
    if (perf_istall !== 32'd0) begin misc++; $display("FAIL dmiss_istall_mask: got %0d expected 0", perf_istall); end
    if (perf_luse !== 32'd0) begin misc++; $display("FAIL dmiss_luse_mask: got %0d expected 0", perf_luse); end
  endtask

  task automatic test_redirect();
    stim_t s; logic [9:0] e, got; int i = 0;
    push(st(1,1,0,1,0,0), RSTV);
    push(st(0,0,0,1,1,0), RDV);
    push(st(0,0,0,1,0,0), BUB);
    push(st(0,1,0,1,0,0), BUB);
    push(st(0,1,0,1,0,0), DEF);
    push(st(0,1,0,1,1,1), RDV);
    push(st(0,1,0,1,0,0), DEF);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      @(posedge clk); #1; drive(s);
      @(negedge clk);
      got = {load_pc, inst_read, load_pipe, rst_pipe}; e = sb.pop_front(); vectors++;
      if (got !== e) begin misc++; $display("FAIL redirect step %0d: got %b expected %b", i, got, e); end
      i++;
    end
    vectors += 2;
    if (perf_flush !== 32'(2*P)) begin misc++; $display("FAIL perf_flush: got %0d expected %0d", perf_flush, 2*P); end
    if (perf_luse !== 32'd0) begin misc++; $display("FAIL redirect_luse: got %0d expected 0", perf_luse); end
  endtask

  task automatic test_dmiss_redirect();
    stim_t s; logic [9:0] e, got; int i = 0;
    push(st(1,1,0,1,0,0), RSTV);
    push(st(0,1,1,0,1,0), DMV);
    push(st(0,1,1,0,1,0), DMV);
    push(st(0,1,1,1,1,0), RDV);
    push(st(0,1,0,1,0,0), DEF);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      @(posedge clk); #1; drive(s);
      @(negedge clk);
      got = {load_pc, inst_read, load_pipe, rst_pipe}; e = sb.pop_front(); vectors++;
      if (got !== e) begin misc++; $display("FAIL dmiss_redirect step %0d: got %b expected %b", i, got, e); end
      i++;
    end
    vectors += 2;
    if (perf_flush !== 32'(1*P)) begin misc++; $display("FAIL dmiss_redirect_flush: got %0d expected %0d", perf_flush, P); end
    if (perf_dstall !== 32'(2*P)) begin misc++; $display("FAIL dmiss_redirect_dstall: got %0d expected %0d", perf_dstall, 2*P); end
  endtask

  task automatic test_kill_cases();
    stim_t s; logic [9:0] e, got; int i = 0;
    push(st(1,1,0,1,0,0), RSTV);
    push(st(0,0,0,1,1,0), RDV);   // enter KILL
    push(st(0,0,0,1,1,0), RDV);   // re-redirect, stay KILL
    push(st(0,0,0,1,0,0), BUB);
    push(st(0,1,0,1,0,0), BUB);   // discard wrong-path word
    push(st(0,1,0,1,0,0), DEF);
    push(st(0,0,0,1,1,0), RDV);
    push(st(0,1,1,0,0,0), DMV);   // word arrives under freeze, ends KILL
    push(st(0,1,0,1,0,0), DEF);
    push(st(0,0,0,1,1,0), RDV);
    push(st(1,0,0,1,0,0), RSTV);  // reset while in KILL
    push(st(0,1,0,1,0,0), DEF);
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      @(posedge clk); #1; drive(s);
      @(negedge clk);
      got = {load_pc, inst_read, load_pipe, rst_pipe}; e = sb.pop_front(); vectors++;
      if (got !== e) begin misc++; $display("FAIL kill step %0d: got %b expected %b", i, got, e); end
      i++;
    end
    vectors++;
    if ({perf_dstall, perf_istall, perf_luse, perf_flush} !== '0) begin
      misc++; $display("FAIL kill_reset_counters: got %0d/%0d/%0d/%0d expected 0", perf_dstall, perf_istall, perf_luse, perf_flush);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    drive(st(1,1,0,1,0,0));
    test_reset();
    test_load_use();
    test_imiss();
    test_dmiss();
    test_redirect();
    test_dmiss_redirect();
    test_kill_cases();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
